// File: rtl/ll_fifo_pkg.sv
// Shared definitions for the LocalLink <-> word-FIFO packers/unpackers:
// word-width derivation, lane index type and occupancy encoding.
package ll_fifo_pkg;

  typedef logic [2:0] lane_idx_t;

  function automatic int occ_width(input int lanes);
    return $clog2(lanes);
  endfunction

  function automatic int fifo_width(input int lanes);
    return 8 * lanes + $clog2(lanes) + 2;
  endfunction

  // occ counts valid bytes modulo the lane count; 0 on a full word
  function automatic lane_idx_t occ_encode(input int nbytes, input int lanes);
    return lane_idx_t'(nbytes % lanes);
  endfunction

endpackage

// File: rtl/ll8_to_fifo_pack_if.sv
// Byte-side LocalLink and word-side FIFO handshake bundle for ll8_to_fifo_pack.
interface ll8_to_fifo_pack_if #(parameter int LANES = 2);
  import ll_fifo_pkg::*;

  localparam int FW = fifo_width(LANES);

  logic [7:0]    ll_data;
  logic          ll_sof;
  logic          ll_eof;
  logic          ll_src_rdy;
  logic          ll_dst_rdy;
  logic [FW-1:0] f_data;
  logic          f_src_rdy_o;
  logic          f_dst_rdy_i;
  logic          resync_err;

  modport master (
    output ll_data, ll_sof, ll_eof, ll_src_rdy, f_dst_rdy_i,
    input  ll_dst_rdy, f_data, f_src_rdy_o, resync_err
  );

  modport slave (
    input  ll_data, ll_sof, ll_eof, ll_src_rdy, f_dst_rdy_i,
    output ll_dst_rdy, f_data, f_src_rdy_o, resync_err
  );

endinterface

// File: rtl/fifo_short.sv
// Small register-based synchronous FIFO; a write is visible on rd_data the next cycle.
module fifo_short #(
  parameter int WIDTH  = 19,
  parameter int AWIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_en
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [AWIDTH:0]   count;
  logic              do_wr, do_rd;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full     = count[AWIDTH];
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign do_wr    = wr_en & ~full;
  assign do_rd    = rd_en & rd_valid;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ll8_to_fifo_pack_core.sv
// Lane counter and holding register that assemble LocalLink bytes into FIFO words.
// LL8_TO_FIFO_PACK_RESYNC_EN enables recovery when sof arrives mid-word.
module ll8_pack_core import ll_fifo_pkg::*; #(
  parameter int LANES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [7:0]                   in_data,
  input  logic                         in_sof,
  input  logic                         in_eof,
  input  logic                         in_valid,
  output logic                         in_rdy,
  input  logic                         space,
  output logic                         push,
  output logic [fifo_width(LANES)-1:0] push_word,
  output logic                         resync_err
);
  localparam int OCC_W = occ_width(LANES);
  localparam int DW    = 8 * LANES;

  logic [OCC_W-1:0] lane, lane_nxt, occ_val;
  logic [DW-1:0]    hold, hold_nxt, merged;
  logic             pend_sof, pend_sof_nxt;
  logic             xfer_in, sof_now;

`ifdef LL8_TO_FIFO_PACK_RESYNC_EN
  // flush holds a sof+eof byte that arrived during a resync until it can be pushed
  logic flush, flush_nxt, resync_nxt;
  assign in_rdy = space & ~flush;
`else
  assign in_rdy     = space;
  assign resync_err = 1'b0;
`endif

  assign xfer_in = in_valid & in_rdy;
  assign sof_now = pend_sof | (in_sof & (lane == '0));
  assign occ_val = in_eof ? OCC_W'(occ_encode(int'(lane) + 1, LANES)) : '0;

  // First byte lands in the MSB lane, later bytes fill descending lanes
  always_comb begin
    merged = hold;
    for (int i = 0; i < LANES; i++) begin
      if (lane == OCC_W'(i)) merged[DW-1-8*i -: 8] = in_data;
    end
  end

  always_comb begin
    push         = 1'b0;
    push_word    = '0;
    lane_nxt     = lane;
    hold_nxt     = hold;
    pend_sof_nxt = pend_sof;
`ifdef LL8_TO_FIFO_PACK_RESYNC_EN
    flush_nxt    = flush;
    resync_nxt   = 1'b0;
    if (flush) begin
      if (space) begin
        push         = 1'b1;
        push_word    = {lane, 1'b1, pend_sof, hold};
        lane_nxt     = '0;
        hold_nxt     = '0;
        pend_sof_nxt = 1'b0;
        flush_nxt    = 1'b0;
      end
    end else if (xfer_in && in_sof && (lane != '0)) begin
      push         = 1'b1;
      push_word    = {lane, 1'b1, pend_sof, hold};
      resync_nxt   = 1'b1;
      lane_nxt     = OCC_W'(1);
      hold_nxt     = {in_data, {(DW-8){1'b0}}};
      pend_sof_nxt = 1'b1;
      flush_nxt    = in_eof;
    end else
`endif
    if (xfer_in) begin
      if (in_eof || (lane == OCC_W'(LANES - 1))) begin
        push         = 1'b1;
        push_word    = {occ_val, in_eof, sof_now, merged};
        lane_nxt     = '0;
        hold_nxt     = '0;
        pend_sof_nxt = 1'b0;
      end else begin
        lane_nxt     = lane + 1'b1;
        hold_nxt     = merged;
        pend_sof_nxt = sof_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane       <= '0;
      hold       <= '0;
      pend_sof   <= 1'b0;
`ifdef LL8_TO_FIFO_PACK_RESYNC_EN
      flush      <= 1'b0;
      resync_err <= 1'b0;
`endif
    end else begin
      lane       <= lane_nxt;
      hold       <= hold_nxt;
      pend_sof   <= pend_sof_nxt;
`ifdef LL8_TO_FIFO_PACK_RESYNC_EN
      flush      <= flush_nxt;
      resync_err <= resync_nxt;
`endif
    end
  end

endmodule

// File: rtl/ll8_to_fifo_pack.sv
// Packs an 8-bit LocalLink stream into LANES-byte {occ,eof,sof,data} FIFO words.
// Optional macro LL8_TO_FIFO_PACK_RESYNC_EN adds mid-word sof recovery.
module ll8_to_fifo_pack import ll_fifo_pkg::*; #(
  parameter int LANES      = 2,
  parameter int OUT_AWIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  ll8_to_fifo_pack_if.slave bus
);
  localparam int FW = fifo_width(LANES);

  logic          full, push;
  logic [FW-1:0] push_word;

  ll8_pack_core #(.LANES(LANES)) u_core (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_data    (bus.ll_data),
    .in_sof     (bus.ll_sof),
    .in_eof     (bus.ll_eof),
    .in_valid   (bus.ll_src_rdy),
    .in_rdy     (bus.ll_dst_rdy),
    .space      (~full),
    .push       (push),
    .push_word  (push_word),
    .resync_err (bus.resync_err)
  );

  fifo_short #(.WIDTH(FW), .AWIDTH(OUT_AWIDTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_data  (push_word),
    .wr_en    (push),
    .full     (full),
    .rd_data  (bus.f_data),
    .rd_valid (bus.f_src_rdy_o),
    .rd_en    (bus.f_dst_rdy_i)
  );

endmodule

// File: tb/tb_ll8_to_fifo_pack.sv
// Directed self-checking bench for ll8_to_fifo_pack with LANES=2 and LANES=4 instances.
module tb_ll8_to_fifo_pack;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  int   checks = 0;
  int   errors = 0;
  int   resync_cycles = 0;
  logic [63:0] got2[$];
  logic [63:0] got4[$];

  ll8_to_fifo_pack_if #(.LANES(2)) bus2 ();
  ll8_to_fifo_pack_if #(.LANES(4)) bus4 ();

  ll8_to_fifo_pack #(.LANES(2), .OUT_AWIDTH(4)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus2)
  );
  ll8_to_fifo_pack #(.LANES(4), .OUT_AWIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus4)
  );

  always #5 clk = ~clk;

  // Inputs change 2ns after posedge, so negedge sees what the next posedge will use
  always @(negedge clk) begin
    if (bus2.f_src_rdy_o && bus2.f_dst_rdy_i) got2.push_back(64'(bus2.f_data));
    if (bus4.f_src_rdy_o && bus4.f_dst_rdy_i) got4.push_back(64'(bus4.f_data));
    if (bus4.resync_err) resync_cycles++;
  end

  function automatic logic [63:0] w2(input logic occ, input logic eof, input logic sof,
                                     input logic [15:0] d);
    return {45'd0, occ, eof, sof, d};
  endfunction

  function automatic logic [63:0] w4(input logic [1:0] occ, input logic eof, input logic sof,
                                     input logic [31:0] d);
    return {28'd0, occ, eof, sof, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setLl(input int sel, input logic [7:0] data, input logic sof,
                       input logic eof, input logic vld);
    if (sel == 2) begin
      bus2.ll_data = data; bus2.ll_sof = sof; bus2.ll_eof = eof; bus2.ll_src_rdy = vld;
    end else begin
      bus4.ll_data = data; bus4.ll_sof = sof; bus4.ll_eof = eof; bus4.ll_src_rdy = vld;
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] data, input logic sof,
                               input logic eof);
    int waited = 0;
    logic rdy;
    setLl(sel, data, sof, eof, 1'b1);
    @(negedge clk);
    rdy = (sel == 2) ? bus2.ll_dst_rdy : bus4.ll_dst_rdy;
    while (!rdy && waited < 200) begin
      waited++;
      @(negedge clk);
      rdy = (sel == 2) ? bus2.ll_dst_rdy : bus4.ll_dst_rdy;
    end
    if (!rdy) checkOutput("byte_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #2;
    setLl(sel, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic compareWords(input string tag, input int sel, input logic [63:0] exp[$]);
    int n;
    logic [63:0] obs;
    n = (sel == 2) ? got2.size() : got4.size();
    checkOutput({tag, "_count"}, 64'(n), 64'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      if (k < n) obs = (sel == 2) ? got2[k] : got4[k];
      else       obs = '1;
      checkOutput($sformatf("%s_w%0d", tag, k), obs, exp[k]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] exp[$];
    int accepted;

    reset = 1'b1;
    clear = 1'b0;
    setLl(2, 8'h00, 1'b0, 1'b0, 1'b0);
    setLl(4, 8'h00, 1'b0, 1'b0, 1'b0);
    bus2.f_dst_rdy_i = 1'b1;
    bus4.f_dst_rdy_i = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_f_src_rdy_2", 64'(bus2.f_src_rdy_o), 64'd0);
    checkOutput("rst_ll_dst_rdy_2", 64'(bus2.ll_dst_rdy), 64'd1);
    checkOutput("rst_resync_2", 64'(bus2.resync_err), 64'd0);
    checkOutput("rst_f_src_rdy_4", 64'(bus4.f_src_rdy_o), 64'd0);
    checkOutput("rst_ll_dst_rdy_4", 64'(bus4.ll_dst_rdy), 64'd1);
    checkOutput("rst_resync_4", 64'(bus4.resync_err), 64'd0);
    @(posedge clk); #2;

    // 4-byte packet, LANES=2
    got2.delete();
    applyStimulus(2, 8'hA1, 1'b1, 1'b0);
    applyStimulus(2, 8'hB2, 1'b0, 1'b0);
    applyStimulus(2, 8'hC3, 1'b0, 1'b0);
    applyStimulus(2, 8'hD4, 1'b0, 1'b1);
    idle(5);
    exp = '{w2(1'b0, 1'b0, 1'b1, 16'hA1B2), w2(1'b0, 1'b1, 1'b0, 16'hC3D4)};
    compareWords("t1", 2, exp);

    // 6-byte packet, LANES=4, partial last word
    got4.delete();
    for (int i = 1; i <= 6; i++) applyStimulus(4, 8'(i), i == 1, i == 6);
    idle(5);
    exp = '{w4(2'd0, 1'b0, 1'b1, 32'h01020304), w4(2'd2, 1'b1, 1'b0, 32'h05060000)};
    compareWords("t2", 4, exp);

    // single-byte packet
    got4.delete();
    applyStimulus(4, 8'h5A, 1'b1, 1'b1);
    idle(5);
    exp = '{w4(2'd1, 1'b1, 1'b1, 32'h5A000000)};
    compareWords("t3", 4, exp);

    // backpressure: 64 bytes into a stalled LANES=2 instance
    got2.delete();
    bus2.f_dst_rdy_i = 1'b0;
    accepted = 0;
    for (int i = 0; i < 64; i++) begin
      setLl(2, 8'(i), i == 0, i == 63, 1'b1);
      @(negedge clk);
      if (!bus2.ll_dst_rdy) break;
      @(posedge clk); #2;
      accepted++;
    end
    checkOutput("t4_accepted", 64'(accepted), 64'd32);
    checkOutput("t4_ll_dst_rdy_low", 64'(bus2.ll_dst_rdy), 64'd0);
    checkOutput("t4_f_src_rdy_high", 64'(bus2.f_src_rdy_o), 64'd1);
    @(posedge clk); #2;
    setLl(2, 8'h00, 1'b0, 1'b0, 1'b0);
    bus2.f_dst_rdy_i = 1'b1;
    for (int i = accepted; i < 64; i++) applyStimulus(2, 8'(i), i == 0, i == 63);
    idle(40);
    exp.delete();
    for (int k = 0; k < 32; k++)
      exp.push_back(w2(1'b0, k == 31, k == 0, {8'(2 * k), 8'(2 * k + 1)}));
    compareWords("t4", 2, exp);

    // clear mid-packet discards the partial word
    got4.delete();
    applyStimulus(4, 8'hAA, 1'b1, 1'b0);
    applyStimulus(4, 8'hBB, 1'b0, 1'b0);
    applyStimulus(4, 8'hCC, 1'b0, 1'b0);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    @(negedge clk);
    checkOutput("t5_clr_f_src_rdy", 64'(bus4.f_src_rdy_o), 64'd0);
    checkOutput("t5_clr_ll_dst_rdy", 64'(bus4.ll_dst_rdy), 64'd1);
    @(posedge clk); #2;
    applyStimulus(4, 8'h11, 1'b1, 1'b0);
    applyStimulus(4, 8'h22, 1'b0, 1'b0);
    applyStimulus(4, 8'h33, 1'b0, 1'b0);
    applyStimulus(4, 8'h44, 1'b0, 1'b1);
    idle(5);
    exp = '{w4(2'd0, 1'b1, 1'b1, 32'h11223344)};
    compareWords("t5", 4, exp);

    // sof arriving mid-word
    got4.delete();
    resync_cycles = 0;
    applyStimulus(4, 8'h01, 1'b1, 1'b0);
    applyStimulus(4, 8'h02, 1'b0, 1'b0);
    applyStimulus(4, 8'h0A, 1'b1, 1'b0);
`ifdef LL8_TO_FIFO_PACK_RESYNC_EN
    checkOutput("t6_resync_pulse", 64'(bus4.resync_err), 64'd1);
`else
    checkOutput("t6_resync_pulse", 64'(bus4.resync_err), 64'd0);
`endif
    applyStimulus(4, 8'h0B, 1'b0, 1'b0);
    checkOutput("t6_resync_after", 64'(bus4.resync_err), 64'd0);
    applyStimulus(4, 8'h0C, 1'b0, 1'b0);
    applyStimulus(4, 8'h0D, 1'b0, 1'b1);
    idle(5);
`ifdef LL8_TO_FIFO_PACK_RESYNC_EN
    checkOutput("t6_resync_cycles", 64'(resync_cycles), 64'd1);
    exp = '{w4(2'd2, 1'b1, 1'b1, 32'h01020000), w4(2'd0, 1'b1, 1'b1, 32'h0A0B0C0D)};
`else
    checkOutput("t6_resync_cycles", 64'(resync_cycles), 64'd0);
    exp = '{w4(2'd0, 1'b0, 1'b1, 32'h01020A0B), w4(2'd2, 1'b1, 1'b0, 32'h0C0D0000)};
`endif
    compareWords("t6", 4, exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
